stream_fifo: RTL and testbench
==============================

STREAM_FIFO -- requirements
Module: stream_fifo

Interface
REQ-001 Parameter DATA_W, default 64: payload width in bits.
REQ-002 Parameter DEPTH_LOG2, default 4: log2 of entry count; DEPTH = 2**DEPTH_LOG2 (16 by default).
REQ-003 clk  input  1: single clock; every register updates on its rising edge.
REQ-004 rst  input  1: synchronous, active-high reset.
REQ-005 src_valid  input  1: upstream beat valid; driven by stream_ctrl dst_valid.
REQ-006 src_data  input  DATA_W: upstream payload; driven by buffer_ctrl stream_d.
REQ-007 src_last  input  1: upstream end-of-packet marker.
REQ-008 src_ready  output  1: FIFO accepts a beat this cycle; equals ~full.
REQ-009 dst_valid  output  1: beat available to M_AXIS_TVALID.
REQ-010 dst_data  output  DATA_W: payload to M_AXIS_TDATA.
REQ-011 dst_last  output  1: end-of-packet to M_AXIS_TLAST.
REQ-012 dst_ready  input  1: downstream accept, from M_AXIS_TREADY.
REQ-013 count  output  DEPTH_LOG2+1: number of stored entries, 0..DEPTH.
REQ-014 full  output  1: count == DEPTH; empty  output  1: count == 0.

Function
REQ-015 Push = src_valid & src_ready; pop = dst_valid & dst_ready; both are evaluated in the same cycle.
REQ-016 Storage is DEPTH entries of {src_last, src_data}; write and read pointers are DEPTH_LOG2 bits wide and wrap modulo DEPTH with no skip.
REQ-017 Operation is first-word-fall-through: dst_data/dst_last present mem[rd_ptr] combinationally, and dst_valid = ~empty.
REQ-018 Latency: a beat pushed at edge N shall appear on dst_valid after edge N (visible in cycle N+1), with no extra bubble when the FIFO is empty.
REQ-019 dst_data, dst_last and dst_valid shall be held stable while dst_valid & ~dst_ready.
REQ-020 Push only: count+1 and wr_ptr+1. Pop only: count-1 and rd_ptr+1. Push and pop together: count unchanged and both pointers advance.
REQ-021 When full, src_ready = 0 even if dst_ready = 1 in that cycle; there is no pass-through on full, so the ready path stays registered-only.
REQ-022 When empty, dst_valid = 0 and dst_data is don't-care; a pop cannot occur.
REQ-023 Beats leave in arrival order with src_last preserved bit-exactly; TLAST packet boundaries are never merged or dropped.
REQ-024 count, full and empty derive from registered state only, with no combinational path from src_valid or dst_ready.

Reset
REQ-025 While rst = 1: wr_ptr = 0, rd_ptr = 0, count = 0, empty = 1, full = 0, dst_valid = 0, src_ready = 0.
REQ-026 The cycle after rst deasserts, src_ready = 1; memory contents need no reset.
REQ-027 Reset mid-operation (top drives rst = ~run) flushes all stored beats; no stale beat appears after reset.

Configuration
REQ-028 Macro STREAM_FIFO_STATS_EN defined: add outputs beat_cnt[31:0] (pops since reset) and pkt_cnt[15:0] (pops with dst_last = 1). Both reset to 0 and wrap modulo 2**width.
REQ-029 Macro STREAM_FIFO_STATS_EN undefined: those ports and counters do not exist, and all other behaviour is identical.

Verification
REQ-030 Reset then push 0x0000_0000_0000_0001..0x10 with dst_ready = 0: count = 16, full = 1 and src_ready = 0 after the 16th; a 17th src_valid is not accepted.
REQ-031 Drain the full FIFO with dst_ready = 1: data 0x1..0x10 in order, one per cycle; empty = 1 and src_ready = 1 after the last pop.
REQ-032 Empty FIFO, push 0xDEAD_BEEF_0000_0001 with last = 1 and dst_ready = 1: dst_valid high in the next cycle with that data and dst_last = 1, popped in that cycle, count back to 0.
REQ-033 Count = 5, simultaneous push and pop for 40 cycles: count stays 5, pointers wrap past 15 without error, and the output sequence matches input order.
REQ-034 Count = 9, assert rst for 1 cycle: dst_valid = 0 and count = 0 in the following cycle; the next pushed beat 0xA5 is the first beat out.
REQ-035 With STREAM_FIFO_STATS_EN: 3 packets of 4 beats fully popped gives beat_cnt = 12 and pkt_cnt = 3.

Source files
------------

// File: rtl/stream_fifo_if.sv
// rtl/stream_fifo_if.sv - handshake bundle for stream_fifo
//
// Purpose: groups the upstream (src_*) and downstream (dst_*) beat handshake
// signals of stream_fifo.
// Ports (signals):
//   src_valid, src_data[DATA_W-1:0], src_last, src_ready  - upstream side
//   dst_valid, dst_data[DATA_W-1:0], dst_last, dst_ready  - downstream side
// Modports:
//   slave  - the FIFO itself
//   master - the environment driving the FIFO (source and sink)
interface stream_fifo_if #(
  parameter int DATA_W = 64
);
  logic              src_valid;
  logic [DATA_W-1:0] src_data;
  logic              src_last;
  logic              src_ready;
  logic              dst_valid;
  logic [DATA_W-1:0] dst_data;
  logic              dst_last;
  logic              dst_ready;

  modport slave (
    input  src_valid, src_data, src_last, dst_ready,
    output src_ready, dst_valid, dst_data, dst_last
  );

  modport master (
    output src_valid, src_data, src_last, dst_ready,
    input  src_ready, dst_valid, dst_data, dst_last
  );
endinterface

// File: rtl/stream_fifo.sv
// rtl/stream_fifo.sv - first-word-fall-through stream FIFO with TLAST
//
// Purpose: DEPTH = 2**DEPTH_LOG2 entry FIFO of {last, data} beats.
// Ports:
//   clk        - single clock, rising edge
//   rst        - synchronous active-high reset, flushes all stored beats
//   bus        - stream_fifo_if.slave (src_* in, dst_* out)
//   count      - stored entries, 0..DEPTH
//   full       - count == DEPTH
//   empty      - count == 0
//   beat_cnt   - pops since reset        (only with STREAM_FIFO_STATS_EN)
//   pkt_cnt    - pops with dst_last = 1  (only with STREAM_FIFO_STATS_EN)
// Optional feature macro: STREAM_FIFO_STATS_EN
module stream_fifo #(
  parameter int DATA_W     = 64,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  stream_fifo_if.slave          bus,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty
`ifdef STREAM_FIFO_STATS_EN
  ,
  output logic [31:0]           beat_cnt,
  output logic [15:0]           pkt_cnt
`endif
);

  localparam int                  DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] CNT_ONE   = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

  logic [DATA_W:0]         mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   wr_ptr;
  logic [DEPTH_LOG2-1:0]   rd_ptr;
  logic [DEPTH_LOG2:0]     count_next;
  logic                    ready_q;
  logic                    push;
  logic                    pop;

  // src_ready is a flop computed from next-cycle occupancy, so there is no
  // combinational path from dst_ready to src_ready (no pass-through on full).
  assign bus.src_ready = ready_q;
  assign push          = bus.src_valid & ready_q;
  assign pop           = bus.dst_valid & bus.dst_ready;

  assign empty         = (count == '0);
  assign full          = (count == DEPTH_CNT);

  // Fall-through read: head entry is always presented.
  assign bus.dst_valid = ~empty;
  assign {bus.dst_last, bus.dst_data} = mem[rd_ptr];

  always_comb begin
    count_next = count;
    unique case ({push, pop})
      2'b10:   count_next = count + CNT_ONE;
      2'b01:   count_next = count - CNT_ONE;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ready_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      count   <= count_next;
      ready_q <= (count_next != DEPTH_CNT);
    end
  end

  // Storage carries no reset; reset only clears the pointers and count.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wr_ptr] <= {bus.src_last, bus.src_data};
    end
  end

`ifdef STREAM_FIFO_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt <= '0;
      pkt_cnt  <= '0;
    end else if (pop) begin
      beat_cnt <= beat_cnt + 32'd1;
      if (bus.dst_last) pkt_cnt <= pkt_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_stream_fifo.sv
// tb/tb_stream_fifo.sv - self-checking scoreboard bench for stream_fifo
module tb_stream_fifo;

  logic       clk;
  logic       rst;
  logic [4:0] count;
  logic       full;
  logic       empty;
`ifdef STREAM_FIFO_STATS_EN
  logic [31:0] beat_cnt;
  logic [15:0] pkt_cnt;
`endif

  int chk;
  int err;
  logic rst_last;
  logic [64:0] sb [$];

  stream_fifo_if #(.DATA_W(64)) bus ();

  stream_fifo #(.DATA_W(64), .DEPTH_LOG2(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus.slave),
    .count (count),
    .full  (full),
    .empty (empty)
`ifdef STREAM_FIFO_STATS_EN
    ,
    .beat_cnt (beat_cnt),
    .pkt_cnt  (pkt_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // One clock cycle: inputs applied at the falling edge, the model decides
  // whether a push/pop happens at the coming rising edge, outputs checked.
  task automatic cycle(input logic v, input logic [63:0] d, input logic l, input logic r);
    logic       m_ready;
    logic [64:0] exp;
    bus.src_valid = v;
    bus.src_data  = d;
    bus.src_last  = l;
    bus.dst_ready = r;
    #1;
    if (rst) begin
      sb.delete();
    end else begin
      m_ready = !rst_last && (sb.size() != 16);
      chk++;
      if (bus.src_ready !== m_ready) begin
        err++;
        $display("FAIL src_ready: got %b want %b", bus.src_ready, m_ready);
      end
      chk++;
      if (count !== 5'(sb.size())) begin
        err++;
        $display("FAIL count: got %0d want %0d", count, sb.size());
      end
      chk++;
      if (bus.dst_valid !== (sb.size() != 0)) begin
        err++;
        $display("FAIL dst_valid: got %b want %b", bus.dst_valid, sb.size() != 0);
      end
      if (r && sb.size() != 0) begin
        exp = sb.pop_front();
        chk++;
        if ({bus.dst_last, bus.dst_data} !== exp) begin
          err++;
          $display("FAIL pop_beat: got last=%b data=%h want last=%b data=%h",
                   bus.dst_last, bus.dst_data, exp[64], exp[63:0]);
        end
      end
      if (v && m_ready) sb.push_back({l, d});
    end
    rst_last = rst;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) cycle(1'b0, 64'd0, 1'b0, 1'b0);
    chk++; if (count !== 5'd0)      begin err++; $display("FAIL rst_count: got %0d want 0", count); end
    chk++; if (empty !== 1'b1)      begin err++; $display("FAIL rst_empty: got %b want 1", empty); end
    chk++; if (full !== 1'b0)       begin err++; $display("FAIL rst_full: got %b want 0", full); end
    chk++; if (bus.dst_valid !== 1'b0) begin err++; $display("FAIL rst_dst_valid: got %b want 0", bus.dst_valid); end
    chk++; if (bus.src_ready !== 1'b0) begin err++; $display("FAIL rst_src_ready: got %b want 0", bus.src_ready); end
    rst = 1'b0;
    cycle(1'b0, 64'd0, 1'b0, 1'b0);
    chk++; if (bus.src_ready !== 1'b1) begin err++; $display("FAIL post_rst_src_ready: got %b want 1", bus.src_ready); end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 16; i++) cycle(1'b1, 64'(i), 1'b0, 1'b0);
    chk++; if (count !== 5'd16)        begin err++; $display("FAIL fill_count: got %0d want 16", count); end
    chk++; if (full !== 1'b1)          begin err++; $display("FAIL fill_full: got %b want 1", full); end
    chk++; if (bus.src_ready !== 1'b0) begin err++; $display("FAIL fill_src_ready: got %b want 0", bus.src_ready); end
    cycle(1'b1, 64'h11, 1'b0, 1'b0);
    chk++; if (count !== 5'd16)        begin err++; $display("FAIL fill_17th: got count %0d want 16", count); end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 16; i++) cycle(1'b0, 64'd0, 1'b0, 1'b1);
    chk++; if (empty !== 1'b1)         begin err++; $display("FAIL drain_empty: got %b want 1", empty); end
    chk++; if (bus.src_ready !== 1'b1) begin err++; $display("FAIL drain_src_ready: got %b want 1", bus.src_ready); end
    chk++; if (sb.size() != 0)         begin err++; $display("FAIL drain_left: got %0d beats left want 0", sb.size()); end
  endtask

  task automatic test_fall_through();
    cycle(1'b1, 64'hDEAD_BEEF_0000_0001, 1'b1, 1'b1);
    chk++; if (bus.dst_valid !== 1'b1) begin err++; $display("FAIL ft_valid: got %b want 1", bus.dst_valid); end
    chk++; if (bus.dst_data !== 64'hDEAD_BEEF_0000_0001) begin err++; $display("FAIL ft_data: got %h want deadbeef00000001", bus.dst_data); end
    chk++; if (bus.dst_last !== 1'b1)  begin err++; $display("FAIL ft_last: got %b want 1", bus.dst_last); end
    cycle(1'b0, 64'd0, 1'b0, 1'b1);
    chk++; if (count !== 5'd0)         begin err++; $display("FAIL ft_count: got %0d want 0", count); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) cycle(1'b1, 64'h100 + 64'(i), 1'(i == 4), 1'b0);
    chk++; if (count !== 5'd5) begin err++; $display("FAIL b2b_pre_count: got %0d want 5", count); end
    for (int i = 0; i < 40; i++) cycle(1'b1, {$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b1);
    chk++; if (count !== 5'd5) begin err++; $display("FAIL b2b_count: got %0d want 5", count); end
    for (int i = 0; i < 5; i++) cycle(1'b0, 64'd0, 1'b0, 1'b1);
    chk++; if (empty !== 1'b1) begin err++; $display("FAIL b2b_empty: got %b want 1", empty); end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 9; i++) cycle(1'b1, 64'h200 + 64'(i), 1'b0, 1'b0);
    chk++; if (count !== 5'd9) begin err++; $display("FAIL mrst_pre_count: got %0d want 9", count); end
    rst = 1'b1;
    cycle(1'b0, 64'd0, 1'b0, 1'b0);
    rst = 1'b0;
    chk++; if (bus.dst_valid !== 1'b0) begin err++; $display("FAIL mrst_valid: got %b want 0", bus.dst_valid); end
    chk++; if (count !== 5'd0)         begin err++; $display("FAIL mrst_count: got %0d want 0", count); end
    cycle(1'b1, 64'hA5, 1'b0, 1'b0);
    cycle(1'b1, 64'hA5, 1'b0, 1'b0);
    cycle(1'b0, 64'd0, 1'b0, 1'b1);
    chk++; if (empty !== 1'b1) begin err++; $display("FAIL mrst_empty: got %b want 1", empty); end
  endtask

`ifdef STREAM_FIFO_STATS_EN
  task automatic test_stats();
    rst = 1'b1;
    cycle(1'b0, 64'd0, 1'b0, 1'b0);
    rst = 1'b0;
    cycle(1'b0, 64'd0, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) cycle(1'b1, 64'h300 + 64'(i), 1'((i % 4) == 3), 1'b0);
    for (int i = 0; i < 12; i++) cycle(1'b0, 64'd0, 1'b0, 1'b1);
    chk++; if (beat_cnt !== 32'd12) begin err++; $display("FAIL stats_beats: got %0d want 12", beat_cnt); end
    chk++; if (pkt_cnt !== 16'd3)   begin err++; $display("FAIL stats_pkts: got %0d want 3", pkt_cnt); end
  endtask
`endif

  initial begin
    chk = 0;
    err = 0;
    rst = 1'b1;
    rst_last = 1'b1;
    bus.src_valid = 1'b0;
    bus.src_data  = '0;
    bus.src_last  = 1'b0;
    bus.dst_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_fill();
    test_drain();
    test_fall_through();
    test_back_to_back();
    test_mid_reset();
`ifdef STREAM_FIFO_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", chk, err);
    $finish;
  end

endmodule
